// File: rtl/demux_rr_scheduler.sv
// Round-robin scheduler for a 1-to-8 demux: one-entry output register, circular
// channel selection over an enable mask, and a wrapping delivery counter.
module demux_rr_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            chanEnable,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic                  inValid,
    output logic                  inReady,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic [2:0]            selectLine,
    output logic [7:0]            outValid,
    input  logic [7:0]            outReady,
    output logic [CNT_WIDTH-1:0]  deliveredCount
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                state_reg, state_next;
    logic [2:0]            rr_ptr_reg, rr_ptr_next;
    logic [DATA_WIDTH-1:0] data_reg, data_next;
    logic [2:0]            sel_reg, sel_next;
    logic [7:0]            valid_reg, valid_next;
    logic [CNT_WIDTH-1:0]  count_reg, count_next;

    logic       drain;
    logic       accept;
    logic [7:0] rotated;
    logic [2:0] offset;
    logic [2:0] pick;

    // Rotate the mask so bit 0 lines up with rr_ptr; the first set bit is the hop distance.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rot
            assign rotated[gi] = chanEnable[rr_ptr_reg + 3'(gi)];
        end
    endgenerate

    always_comb begin
        offset = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = 3'(i);
            end
        end
    end

    assign pick    = rr_ptr_reg + offset;
    assign drain   = (state_reg == FULL) && outReady[sel_reg];
    assign inReady = (|chanEnable) && ((state_reg == EMPTY) || drain);
    assign accept  = inValid && inReady;

    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        data_next   = data_reg;
        sel_next    = sel_reg;
        valid_next  = valid_reg;
        count_next  = count_reg;
        if (accept) begin
            state_next  = FULL;
            data_next   = dataIn;
            sel_next    = pick;
            rr_ptr_next = pick + 3'd1;
            valid_next  = 8'd1 << pick;
        end else if (drain) begin
            // Word and select stay parked so the last delivery remains observable.
            state_next = EMPTY;
            valid_next = 8'd0;
        end
        if (drain) begin
            count_next = count_reg + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= EMPTY;
            rr_ptr_reg <= 3'd0;
            data_reg   <= '0;
            sel_reg    <= 3'd0;
            valid_reg  <= 8'd0;
            count_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            data_reg   <= data_next;
            sel_reg    <= sel_next;
            valid_reg  <= valid_next;
            count_reg  <= count_next;
        end
    end

    assign dataOut        = data_reg;
    assign selectLine     = sel_reg;
    assign outValid       = valid_reg;
    assign deliveredCount = count_reg;

endmodule

// File: doc/demux_rr_scheduler.md
# demux_rr_scheduler

Round-robin scheduler that sequences the 1-to-8 demultiplexer datapath. It accepts a word stream over a valid/ready handshake and holds each word in a one-entry output register. Each word is assigned to the next enabled output channel in circular order, and the scheduler drives the demux select and a one-hot per-channel valid until that channel accepts. It sits between a single producer and eight consumer channels, and owns channel selection, back-pressure and delivery accounting.

## Interface
- DATA_WIDTH, 8: width of dataIn/dataOut.
- CNT_WIDTH, 16: width of deliveredCount.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  one clock; reset is synchronous and active-high.
- chanEnable  input  8  per-channel enable mask; bit i allows channel i to be selected.
- dataIn  input  DATA_WIDTH  input word.
- inValid  input  1  dataIn valid.
- inReady  output  1  scheduler can accept dataIn this cycle (combinational).
- dataOut  output  DATA_WIDTH  held word, broadcast to all channels.
- selectLine  output  3  channel index of held word (demux select).
- outValid  output  8  one-hot; bit selectLine set while a word is held, else all zero.
- outReady  input  8  per-channel accept.
- deliveredCount  output  CNT_WIDTH  number of completed deliveries, wraps modulo 2^CNT_WIDTH.

## Operation
- Two-state machine:
  - EMPTY: no word held; outValid=0.
  - FULL: word held in dataOut for channel selectLine.
- Accept: inValid && inReady. Complete (drain): state FULL && outReady[selectLine].
- inReady = |chanEnable && (state==EMPTY || drain).
- Selection at accept: sel = first i in the order rrPtr, rrPtr+1, …, rrPtr+7 (mod 8) with chanEnable[i]=1. Computed from chanEnable and rrPtr in the accept cycle.
- On accept:
  - dataOut<=dataIn, selectLine<=sel, rrPtr<=(sel+1) mod 8, state<=FULL.
  - Applies in both EMPTY and FULL-with-drain.
- On drain without accept: state<=EMPTY; selectLine and dataOut hold their last values.
- On every drain: deliveredCount<=deliveredCount+1, wrapping from all-ones to 0.
- Stall: in FULL with outReady[selectLine]=0, dataOut, selectLine and outValid are held stable. outReady bits of other channels are ignored.
- chanEnable=0: inReady=0 and no accept occurs. A word already held is still delivered.
- Clearing chanEnable[selectLine] while FULL does not cancel or redirect the held word. The enable mask affects selection only.
- A single enabled channel receives every word, and rrPtr advances to that channel+1 each time.
- Reset values: state EMPTY, rrPtr=0, dataOut=0, selectLine=0, outValid=0, deliveredCount=0. inReady follows its equation (it is 1 after reset when chanEnable!=0).
- Reset asserted mid-operation discards any held word without counting it. Reset has priority over accept and drain in the same cycle.

## Timing
- Latency: word accepted at edge N is presented on dataOut/outValid from edge N (visible in cycle N+1).
- Throughput: one word per cycle when the target channel asserts outReady in the cycle it is presented. Simultaneous drain and accept is allowed.
- outValid, dataOut and selectLine are registered.
- inReady is combinational from state, chanEnable and outReady[selectLine]. There is no path from inValid to inReady.
- deliveredCount updates on the edge of the drain; the new value is visible the next cycle.

## Test plan
- Reset, then chanEnable=8'hFF with all outReady=1:
  - Stimulus: stream 10 words 0x00..0x09 back-to-back.
  - Required: channels 0,1,…,7,0,1 in order; outValid one-hot 8'h01, 8'h02, …; one delivery per cycle; deliveredCount=10.
- chanEnable=8'b1010_0100, outReady=8'hFF:
  - Stimulus: 4 words.
  - Required: selectLine sequence 2,5,7,2.
- Back-pressure:
  - Stimulus: word 0xA5 to channel 3, outReady[3]=0 for 5 cycles, inValid held high.
  - Required: inReady=0 for 5 cycles; dataOut=0xA5 and outValid=8'h08 stable throughout; asserting outReady[4..7] has no effect.
  - Then outReady[3]=1: the drain and the next accept occur in the same cycle.
- Enable edge cases:
  - chanEnable=0 with inValid=1: inReady=0, no accept.
  - Word held for channel 6 and chanEnable[6] cleared: the word is still delivered to channel 6 when outReady[6]=1.
- Counter wrap with CNT_WIDTH=4:
  - Stimulus: 17 deliveries.
  - Required: deliveredCount=1.
- Reset mid-operation:
  - Stimulus: assert reset while FULL with outReady=0.
  - Required: next cycle outValid=0, deliveredCount=0, rrPtr=0; the first post-reset word goes to the lowest enabled channel.
